// File: rtl/grostl_pkg.sv
// Shared types for the Groestl masked SubBytes datapath, plus a golden AES S-box table
// used only by the testbench.
package grostl_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

   localparam logic [0:255][7:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic byte_t sbox_ref(input byte_t x);
      logic [0:255][7:0] tbl;
      tbl = SBOX_TBL;
      return tbl[x];
   endfunction

endpackage

// File: rtl/grostl_sbox_slice_m.sv
// NUM_SBOX parallel masked S-box cells. Each cell works on the two additive shares
// (masked byte, mask) throughout; the shares are only merged after the output mask is applied.
module grostl_sbox_slice_m
   import grostl_pkg::*;
#(
   parameter int unsigned NUM_SBOX = 8
) (
   input  logic                     enc_i,
   input  logic [0:NUM_SBOX-1][7:0] din_i,
   input  logic [0:NUM_SBOX-1][7:0] imask_i,
   input  logic [0:NUM_SBOX-1][7:0] omask_i,
   output logic [0:NUM_SBOX-1][7:0] dout_o
);

   typedef logic [0:1][7:0] shares_t;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic byte_t gf_mul(input byte_t a, input byte_t b);
      byte_t p;
      byte_t aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic shares_t sq_sh(input shares_t s);
      shares_t r;
      r[0] = gf_mul(s[0], s[0]);
      r[1] = gf_mul(s[1], s[1]);
      return r;
   endfunction

   // Cross products keep each output share tied to one share of the left operand.
   function automatic shares_t mul_sh(input shares_t a, input shares_t b);
      shares_t r;
      r[0] = gf_mul(a[0], b[0]) ^ gf_mul(a[0], b[1]);
      r[1] = gf_mul(a[1], b[0]) ^ gf_mul(a[1], b[1]);
      return r;
   endfunction

   // Inversion as x^254 over shares.
   function automatic shares_t inv_sh(input shares_t x);
      shares_t x2, x3, x12, x15, x240, x252;
      x2   = sq_sh(x);
      x3   = mul_sh(x2, x);
      x12  = sq_sh(sq_sh(x3));
      x15  = mul_sh(x12, x3);
      x240 = sq_sh(sq_sh(sq_sh(sq_sh(x15))));
      x252 = mul_sh(x240, x12);
      return mul_sh(x252, x2);
   endfunction

   function automatic byte_t aff_fwd(input byte_t a);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]};
   endfunction

   function automatic byte_t aff_inv(input byte_t a);
      return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]};
   endfunction

   function automatic byte_t masked_sbox(input logic enc, input byte_t d, input byte_t m,
                                         input byte_t om);
      shares_t s;
      shares_t y;
      byte_t   r;
      if (enc) begin
         s[0] = d;
         s[1] = m;
      end else begin
         s[0] = aff_inv(d) ^ 8'h05;
         s[1] = aff_inv(m);
      end
      y = inv_sh(s);
      if (enc) r = (aff_fwd(y[0]) ^ om ^ 8'h63) ^ aff_fwd(y[1]);
      else     r = (y[0] ^ om) ^ y[1];
      return r;
   endfunction

   for (genvar g = 0; g < NUM_SBOX; g++) begin : g_cell
      assign dout_o[g] = masked_sbox(enc_i, din_i[g], imask_i[g], omask_i[g]);
   end

endmodule

// File: rtl/grostl_sub_bytes_seq_m.sv
// Multi-cycle masked SubBytes: latches a masked state, runs NUM_SBOX cells over
// NUM_BYTES/NUM_SBOX beats, then holds the result until the downstream handshake.
module grostl_sub_bytes_seq_m
   import grostl_pkg::*;
#(
   parameter int unsigned NUM_BYTES  = 64,
   parameter int unsigned NUM_SBOX   = 8,
   parameter bit          CLEAR_REGS = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [0:NUM_BYTES-1][7:0] din_i,
   input  logic [0:NUM_BYTES-1][7:0] imask_i,
   input  logic [0:NUM_BYTES-1][7:0] omask_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [0:NUM_BYTES-1][7:0] dout_o
);

   localparam int unsigned NUM_BEATS = NUM_BYTES / NUM_SBOX;
   localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int unsigned SLICE_W   = NUM_SBOX * 8;

   if (NUM_BYTES % NUM_SBOX != 0) begin : g_param_check
      $error("NUM_SBOX must divide NUM_BYTES");
   end

   // Beat-major view: element k holds bytes k*NUM_SBOX .. k*NUM_SBOX+NUM_SBOX-1.
   typedef logic [0:NUM_BEATS-1][SLICE_W-1:0] beats_t;

   beats_t                   din_q, imask_q, omask_q, dout_q;
   state_e                   state_q;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     last_beat;
   logic                     in_ready_q, out_valid_q;
   logic [0:NUM_SBOX-1][7:0] slice_res;

   always_comb begin
      last_beat = (cnt_q == CNT_W'(NUM_BEATS - 1));
      cnt_d     = last_beat ? '0 : cnt_q + 1'b1;
   end

   grostl_sbox_slice_m #(
      .NUM_SBOX(NUM_SBOX)
   ) u_slice (
      .enc_i   (1'b1),
      .din_i   (din_q[cnt_q]),
      .imask_i (imask_q[cnt_q]),
      .omask_i (omask_q[cnt_q]),
      .dout_o  (slice_res)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         din_q       <= '0;
         imask_q     <= '0;
         omask_q     <= '0;
         dout_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid_i && in_ready_q) begin
                  din_q      <= beats_t'(din_i);
                  imask_q    <= beats_t'(imask_i);
                  omask_q    <= beats_t'(omask_i);
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_RUN;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            ST_RUN: begin
               dout_q[cnt_q] <= slice_res;
               cnt_q         <= cnt_d;
               if (last_beat) begin
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
                  // Scrub shares and result so nothing from this call lingers.
                  if (CLEAR_REGS) begin
                     din_q   <= '0;
                     imask_q <= '0;
                     omask_q <= '0;
                     dout_q  <= '0;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   // Partially written results stay internal until the whole state is done.
   assign dout_o      = out_valid_q ? dout_q : '0;

endmodule

// File: tb/tb_grostl_sub_bytes_seq_m.sv
// Randomised self-checking bench for grostl_sub_bytes_seq_m against a byte-wise
// table model S(din ^ imask) ^ omask.
module tb_grostl_sub_bytes_seq_m;
   import grostl_pkg::*;

   localparam int unsigned NB = 64;
   typedef logic [0:NB-1][7:0] state_t;

   logic   clk;
   logic   reset;
   logic   in_valid, in_ready, out_valid, out_ready;
   state_t din, imask, omask, dout;
   logic   pv_valid, pv_ready;
   logic   w_ready, w_valid, n_ready, n_valid;
   state_t w_dout, n_dout;

   int unsigned n_checks;
   int unsigned n_errors;

   grostl_sub_bytes_seq_m u_dut (
      .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .din_i(din), .imask_i(imask), .omask_i(omask), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .dout_o(dout)
   );

   grostl_sub_bytes_seq_m #(.NUM_BYTES(64), .NUM_SBOX(64), .CLEAR_REGS(1'b1)) u_wide (
      .clk_i(clk), .reset_i(reset), .in_valid_i(pv_valid), .in_ready_o(w_ready),
      .din_i(din), .imask_i(imask), .omask_i(omask), .out_valid_o(w_valid),
      .out_ready_i(pv_ready), .dout_o(w_dout)
   );

   grostl_sub_bytes_seq_m #(.NUM_BYTES(64), .NUM_SBOX(1), .CLEAR_REGS(1'b1)) u_narrow (
      .clk_i(clk), .reset_i(reset), .in_valid_i(pv_valid), .in_ready_o(n_ready),
      .din_i(din), .imask_i(imask), .omask_i(omask), .out_valid_o(n_valid),
      .out_ready_i(pv_ready), .dout_o(n_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic state_t rand_state();
      state_t r;
      for (int i = 0; i < NB; i++) r[i] = 8'($urandom_range(0, 255));
      return r;
   endfunction

   function automatic state_t ref_sub_bytes(input state_t d, input state_t im, input state_t om);
      state_t r;
      for (int i = 0; i < NB; i++) r[i] = sbox_ref(d[i] ^ im[i]) ^ om[i];
      return r;
   endfunction

   task automatic send_state(input string tag, input state_t d, input state_t im,
                             input state_t om);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check_eq({tag, "_rdy"}, 512'(in_ready), 512'(1));
      din      = d;
      imask    = im;
      omask    = om;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_txn(input string tag, input state_t d, input state_t im,
                          input state_t om, output state_t got);
      int lat;
      send_state(tag, d, im, om);
      wait_valid(lat);
      check_eq({tag, "_lat"}, 512'(lat), 512'(8));
      got = dout;
      check_eq({tag, "_dout"}, dout, ref_sub_bytes(d, im, om));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq({tag, "_ovld_off"}, 512'(out_valid), 512'(0));
      check_eq({tag, "_rdy_back"}, 512'(in_ready), 512'(1));
   endtask

   initial begin
      state_t d, im, om, x, got, exp, z63;
      int     lat, bad, lat_w, lat_n, n;

      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      pv_valid = 1'b0;
      pv_ready = 1'b0;
      din      = '0;
      imask    = '0;
      omask    = '0;
      for (int i = 0; i < NB; i++) z63[i] = 8'h63;

      // Reset state.
      tick();
      tick();
      check_eq("rst_rdy", 512'(in_ready), 512'(0));
      check_eq("rst_ovld", 512'(out_valid), 512'(0));
      check_eq("rst_dout", dout, 512'(0));
      check_eq("rst_doutq", u_dut.dout_q, 512'(0));
      reset = 1'b0;
      tick();
      check_eq("rst_rdy_after", 512'(in_ready), 512'(1));

      // Zero vector.
      run_txn("zero", '0, '0, '0, got);
      check_eq("zero_all63", got, z63);

      // Single masked byte.
      d = '0; im = '0; om = '0;
      d[0] = 8'hF6; im[0] = 8'hA5; om[0] = 8'h3C;
      run_txn("mbyte", d, im, om, got);
      check_eq("mbyte_b0", 512'(got[0]), 512'(8'hD1));
      check_eq("mbyte_b1", 512'(got[1]), 512'(8'h63));

      // Randomised plain values and masks.
      for (int t = 0; t < 1000; t++) begin
         x  = rand_state();
         im = rand_state();
         om = rand_state();
         run_txn("rand", x ^ im, im, om, got);
      end

      // Backpressure in DONE.
      d = rand_state(); im = rand_state(); om = rand_state();
      exp = ref_sub_bytes(d, im, om);
      send_state("bp", d, im, om);
      wait_valid(lat);
      check_eq("bp_lat", 512'(lat), 512'(8));
      for (int c = 0; c < 20; c++) begin
         check_eq("bp_dout", dout, exp);
         check_eq("bp_ovld", 512'(out_valid), 512'(1));
         check_eq("bp_rdy", 512'(in_ready), 512'(0));
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("bp_ovld_off", 512'(out_valid), 512'(0));
      check_eq("bp_rdy_on", 512'(in_ready), 512'(1));
      check_eq("bp_dout_zero", dout, 512'(0));
      check_eq("bp_clr_din", u_dut.din_q, 512'(0));
      check_eq("bp_clr_imask", u_dut.imask_q, 512'(0));
      check_eq("bp_clr_omask", u_dut.omask_q, 512'(0));
      check_eq("bp_clr_dout", u_dut.dout_q, 512'(0));

      // Reset during RUN at beat 3.
      d = rand_state(); im = rand_state(); om = rand_state();
      send_state("mrst", d, im, om);
      for (int c = 0; c < 3; c++) begin
         check_eq("mrst_run_ovld", 512'(out_valid), 512'(0));
         check_eq("mrst_run_dout", dout, 512'(0));
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("mrst_dout", dout, 512'(0));
      check_eq("mrst_doutq", u_dut.dout_q, 512'(0));
      check_eq("mrst_rdy", 512'(in_ready), 512'(0));
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) bad++;
         tick();
      end
      check_eq("mrst_no_ovld", 512'(bad), 512'(0));
      run_txn("mrst_next", rand_state(), rand_state(), rand_state(), got);

      // in_valid held high while busy, out_ready held high early.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         d = rand_state(); im = rand_state(); om = rand_state();
         din = d; imask = im; omask = om;
         n = 0;
         while (!in_ready && n < 20) begin
            tick();
            n++;
         end
         check_eq("busy_rdy", 512'(in_ready), 512'(1));
         exp = ref_sub_bytes(d, im, om);
         tick();
         din = rand_state(); imask = rand_state(); omask = rand_state();
         lat = 0;
         bad = 0;
         while (!out_valid && lat < 200) begin
            if (in_ready) bad++;
            tick();
            lat++;
         end
         check_eq("busy_no_accept", 512'(bad), 512'(0));
         check_eq("busy_lat", 512'(lat), 512'(8));
         check_eq("busy_dout", dout, exp);
         tick();
         check_eq("busy_ovld_off", 512'(out_valid), 512'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // Alternate slice widths: one beat and sixty-four beats.
      for (int v = 0; v < 2; v++) begin
         d = rand_state(); im = rand_state(); om = rand_state();
         din = d; imask = im; omask = om;
         exp = ref_sub_bytes(d, im, om);
         n = 0;
         while (!(w_ready && n_ready) && n < 20) begin
            tick();
            n++;
         end
         check_eq("par_rdy", 512'(w_ready && n_ready), 512'(1));
         pv_valid = 1'b1;
         tick();
         pv_valid = 1'b0;
         lat_w = -1;
         lat_n = -1;
         for (int c = 1; c <= 100; c++) begin
            tick();
            if (w_valid && lat_w < 0) lat_w = c;
            if (n_valid && lat_n < 0) lat_n = c;
            if (lat_w >= 0 && lat_n >= 0) break;
         end
         check_eq("par_lat_wide", 512'(lat_w), 512'(1));
         check_eq("par_lat_narrow", 512'(lat_n), 512'(64));
         check_eq("par_dout_wide", w_dout, exp);
         check_eq("par_dout_narrow", n_dout, exp);
         pv_ready = 1'b1;
         tick();
         pv_ready = 1'b0;
         check_eq("par_ovld_off", 512'(w_valid || n_valid), 512'(0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
